// File: rtl/alu_ctrl_seq_if.sv
// Issue-side bundle between the main decoder and the ALU control sequencer.
// master = decoder/pipeline side, slave = alu_ctrl_seq.
interface alu_ctrl_seq_if #(
  parameter int unsigned CTRL_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        ALUOp;
  logic [2:0]        funct3;
  logic              funct7_5;
  logic              funct7_0;
  logic              op_5;
  logic              flush;
  logic [CTRL_W-1:0] ALUControl;
  logic              is_mdu;
  logic              out_valid;
  logic              stall;

  modport master (
    output in_valid, ALUOp, funct3, funct7_5, funct7_0, op_5, flush,
    input  in_ready, ALUControl, is_mdu, out_valid, stall
  );

  modport slave (
    input  in_valid, ALUOp, funct3, funct7_5, funct7_0, op_5, flush,
    output in_ready, ALUControl, is_mdu, out_valid, stall
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered RV32IM ALU control decoder; holds multi-cycle MUL/DIV control
// words and back-pressures issue until the configured latency has elapsed.
module alu_ctrl_seq #(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned DIV_LATENCY = 33,
  parameter int unsigned CTRL_W      = 5
) (
  input logic           clk,
  input logic           rst,
  alu_ctrl_seq_if.slave bus
);

  localparam logic [4:0] OpAdd  = 5'b00000;
  localparam logic [4:0] OpSub  = 5'b00001;
  localparam logic [4:0] OpAnd  = 5'b00010;
  localparam logic [4:0] OpOr   = 5'b00011;
  localparam logic [4:0] OpXor  = 5'b00100;
  localparam logic [4:0] OpSlt  = 5'b00101;
  localparam logic [4:0] OpSltu = 5'b00110;
  localparam logic [4:0] OpSll  = 5'b00111;
  localparam logic [4:0] OpSrl  = 5'b01000;
  localparam logic [4:0] OpSra  = 5'b01001;

  localparam logic [7:0] MulLat = 8'(MUL_LATENCY);
  localparam logic [7:0] DivLat = 8'(DIV_LATENCY);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              mdu_q;
  logic              vld_q;

  logic [4:0] dec_op;
  logic       dec_mdu;
  logic [7:0] dec_lat;

  always_comb begin
    dec_op  = OpAdd;
    dec_mdu = 1'b0;
    dec_lat = 8'd1;
    case (bus.ALUOp)
      2'b01: begin
        case (bus.funct3)
          3'b000, 3'b001: dec_op = OpSub;
          3'b100, 3'b101: dec_op = OpSlt;
          3'b110, 3'b111: dec_op = OpSltu;
          default:        dec_op = OpAdd;
        endcase
      end
      2'b10: begin
        if (bus.op_5 && bus.funct7_0) begin
          // M-ops encode as 10 followed by funct3; funct3[2] splits mul/div.
          dec_op  = {2'b10, bus.funct3};
          dec_mdu = 1'b1;
          dec_lat = bus.funct3[2] ? DivLat : MulLat;
        end else begin
          case (bus.funct3)
            3'b000:  dec_op = (bus.op_5 && bus.funct7_5) ? OpSub : OpAdd;
            3'b001:  dec_op = OpSll;
            3'b010:  dec_op = OpSlt;
            3'b011:  dec_op = OpSltu;
            3'b100:  dec_op = OpXor;
            3'b101:  dec_op = bus.funct7_5 ? OpSra : OpSrl;
            3'b110:  dec_op = OpOr;
            default: dec_op = OpAnd;
          endcase
        end
      end
      default: dec_op = OpAdd;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      mdu_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else if (bus.flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      mdu_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            ctrl_q <= CTRL_W'(dec_op);
            mdu_q  <= dec_mdu;
            if (dec_lat > 8'd1) begin
              state_q <= StBusy;
              cnt_q   <= dec_lat - 8'd1;
            end else begin
              vld_q <= 1'b1;
            end
          end
        end
        StBusy: begin
          if (cnt_q > 8'd1) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            state_q <= StIdle;
            cnt_q   <= '0;
            vld_q   <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.stall      = (state_q == StBusy);
  assign bus.ALUControl = ctrl_q;
  assign bus.is_mdu     = mdu_q;
  assign bus.out_valid  = vld_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: decode vector table, completion scoreboard and
// hand sequences for DIV timing, flush, async reset and MUL latency.
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.CTRL_W(5)) bus ();
  alu_ctrl_seq_if #(.CTRL_W(5)) bus2 ();

  // Second unit sees identical inputs but uses the default MUL latency.
  assign bus2.in_valid = bus.in_valid;
  assign bus2.ALUOp    = bus.ALUOp;
  assign bus2.funct3   = bus.funct3;
  assign bus2.funct7_5 = bus.funct7_5;
  assign bus2.funct7_0 = bus.funct7_0;
  assign bus2.op_5     = bus.op_5;
  assign bus2.flush    = bus.flush;

  alu_ctrl_seq #(.MUL_LATENCY(1), .DIV_LATENCY(33), .CTRL_W(5)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  alu_ctrl_seq #(.MUL_LATENCY(2), .DIV_LATENCY(33), .CTRL_W(5)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [4:0] ctrl; logic mdu;} exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  typedef struct {
    logic [1:0] aluop;
    logic [2:0] f3;
    logic       f75;
    logic       f70;
    logic       op5;
    logic [4:0] ctrl;
    logic       mdu;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] aluop, input logic [2:0] f3, input logic f75,
                        input logic f70, input logic op5, input logic v, input logic fl);
    bus.ALUOp    = aluop;
    bus.funct3   = f3;
    bus.funct7_5 = f75;
    bus.funct7_0 = f70;
    bus.op_5     = op5;
    bus.in_valid = v;
    bus.flush    = fl;
  endtask

  // Scoreboard: every completion pulse must match the oldest outstanding op.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious out_valid", bus.out_valid, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("ALUControl at completion", bus.ALUControl, mon_e.ctrl);
        check("is_mdu at completion", bus.is_mdu, mon_e.mdu);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_stall, n_pulse, n_ctrl;

  initial begin
    rst = 1'b1;
    set_in(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", bus.in_ready, 1);
    check("reset stall", bus.stall, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset ALUControl", bus.ALUControl, 0);
    check("reset is_mdu", bus.is_mdu, 0);
    check("reset in_ready dut2", bus2.in_ready, 1);

    // aluop, f3, f7_5, f7_0, op5, expected ctrl, expected mdu
    vecs.push_back('{2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 5'b00001, 1'b0});  // sub
    vecs.push_back('{2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0});  // addi, bit30 set
    vecs.push_back('{2'b01, 3'b000, 1'b0, 1'b0, 1'b1, 5'b00001, 1'b0});
    vecs.push_back('{2'b01, 3'b001, 1'b0, 1'b0, 1'b1, 5'b00001, 1'b0});
    vecs.push_back('{2'b01, 3'b100, 1'b0, 1'b0, 1'b1, 5'b00101, 1'b0});
    vecs.push_back('{2'b01, 3'b101, 1'b0, 1'b0, 1'b1, 5'b00101, 1'b0});
    vecs.push_back('{2'b01, 3'b111, 1'b0, 1'b0, 1'b1, 5'b00110, 1'b0});
    vecs.push_back('{2'b01, 3'b010, 1'b0, 1'b0, 1'b1, 5'b00000, 1'b0});
    vecs.push_back('{2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 5'b01001, 1'b0});  // sra
    vecs.push_back('{2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 5'b01000, 1'b0});  // srl
    vecs.push_back('{2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 5'b01001, 1'b0});  // srai
    vecs.push_back('{2'b00, 3'b111, 1'b1, 1'b1, 1'b1, 5'b00000, 1'b0});
    vecs.push_back('{2'b11, 3'b001, 1'b1, 1'b1, 1'b1, 5'b00000, 1'b0});
    vecs.push_back('{2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 5'b00111, 1'b0});
    vecs.push_back('{2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 5'b00101, 1'b0});
    vecs.push_back('{2'b10, 3'b011, 1'b0, 1'b0, 1'b0, 5'b00110, 1'b0});
    vecs.push_back('{2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 5'b00100, 1'b0});
    vecs.push_back('{2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 5'b00011, 1'b0});
    vecs.push_back('{2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 5'b00010, 1'b0});
    vecs.push_back('{2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b0});  // I-type, bit25 set
    vecs.push_back('{2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 5'b10000, 1'b1});  // mul
    vecs.push_back('{2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 5'b10001, 1'b1});  // mulh
    vecs.push_back('{2'b10, 3'b010, 1'b0, 1'b1, 1'b1, 5'b10010, 1'b1});  // mulhsu
    vecs.push_back('{2'b10, 3'b011, 1'b0, 1'b1, 1'b1, 5'b10011, 1'b1});  // mulhu

    foreach (vecs[i]) begin
      set_in(vecs[i].aluop, vecs[i].f3, vecs[i].f75, vecs[i].f70, vecs[i].op5, 1'b1, 1'b0);
      sb_q.push_back('{vecs[i].ctrl, vecs[i].mdu});
      @(posedge clk);
      #1;
      check("in_ready during single-cycle stream", bus.in_ready, 1);
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // DIV accepted at edge 0: busy cycles 1..32, pulse in cycle 33.
    set_in(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sb_q.push_back('{5'b10100, 1'b1});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_stall = 0; n_pulse = 0; n_ctrl = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (bus.stall && !bus.in_ready) n_stall++;
      if (bus.out_valid) n_pulse++;
      if (bus.ALUControl == 5'b10100) n_ctrl++;
      @(posedge clk);
      #1;
    end
    check("DIV busy cycles", n_stall, 32);
    check("DIV early pulses", n_pulse, 0);
    check("DIV control held", n_ctrl, 32);
    set_in(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sb_q.push_back('{5'b10100, 1'b1});
    @(negedge clk);
    check("DIV out_valid cycle 33", bus.out_valid, 1);
    check("DIV in_ready cycle 33", bus.in_ready, 1);
    check("DIV stall cycle 33", bus.stall, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("second DIV accepted", bus.stall, 1);

    // Flush in cycle 10 of the second DIV.
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    sb_q.delete(sb_q.size() - 1);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush stall", bus.stall, 0);
    check("flush out_valid", bus.out_valid, 0);
    check("flush ALUControl", bus.ALUControl, 0);
    check("flush is_mdu", bus.is_mdu, 0);
    check("flush in_ready", bus.in_ready, 1);
    n_pulse = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.out_valid) n_pulse++;
    end
    check("pulses after flush", n_pulse, 0);

    // Flush together with in_valid in IDLE must not accept.
    @(posedge clk);
    #1;
    set_in(2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    sb_q.push_back('{5'b00100, 1'b0});
    @(posedge clk);
    #1;
    set_in(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    set_in(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("flush+valid out_valid", bus.out_valid, 0);
    check("flush+valid ALUControl", bus.ALUControl, 0);
    check("flush+valid in_ready", bus.in_ready, 1);

    // Asynchronous reset between edges while BUSY.
    set_in(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sb_q.push_back('{5'b10110, 1'b1});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    sb_q.delete();
    #1;
    check("async reset stall", bus.stall, 0);
    check("async reset in_ready", bus.in_ready, 1);
    check("async reset ALUControl", bus.ALUControl, 0);
    check("async reset is_mdu", bus.is_mdu, 0);
    check("async reset out_valid", bus.out_valid, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // MUL after reset; second unit (MUL_LATENCY=2) goes BUSY for one cycle.
    @(posedge clk);
    #1;
    set_in(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sb_q.push_back('{5'b10000, 1'b1});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat2 MUL stall cycle 1", bus2.stall, 1);
    check("lat2 MUL out_valid cycle 1", bus2.out_valid, 0);
    @(negedge clk);
    check("lat2 MUL out_valid cycle 2", bus2.out_valid, 1);
    check("lat2 MUL ALUControl", bus2.ALUControl, 5'b10000);
    check("lat2 MUL stall cycle 2", bus2.stall, 0);

    // Ten back-to-back single-cycle MULs.
    @(posedge clk);
    #1;
    set_in(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_pulse = 0;
    for (int i = 0; i < 10; i++) begin
      sb_q.push_back('{5'b10000, 1'b1});
      @(posedge clk);
      if (i == 9) begin
        #1;
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.out_valid && bus.in_ready) n_pulse++;
    end
    check("MUL consecutive pulses", n_pulse, 10);
    @(negedge clk);
    check("MUL pulse train ends", bus.out_valid, 0);

    repeat (3) @(posedge clk);
    check("scoreboard drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
